// File: rtl/rs_codeword_serializer_if.sv
//==============================================================================
// Module      : rs_codeword_serializer_if
// Description : Bus bundle between the RS(255,239) encoder side and the
//               codeword serializer. The master drives message bytes and the
//               encoder parity snapshot. The slave returns the serialized
//               codeword stream and the flow-control and status flags.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface rs_codeword_serializer_if #(
    parameter int NPAR = 16,
    parameter int W    = 8
);
    logic [W-1:0]      in_data;
    logic              in_valid;
    logic [NPAR*W-1:0] par_in;
    logic              in_busy;
    logic              enc_clr;
    logic [W-1:0]      out_data;
    logic              out_valid;
    logic              out_sop;
    logic              out_eop;
    logic [7:0]        cnt;
    logic              ovf_err;

    modport master (
        output in_data, in_valid, par_in,
        input  in_busy, enc_clr, out_data, out_valid, out_sop, out_eop, cnt, ovf_err
    );

    modport slave (
        input  in_data, in_valid, par_in,
        output in_busy, enc_clr, out_data, out_valid, out_sop, out_eop, cnt, ovf_err
    );
endinterface

`default_nettype wire

// File: rtl/rs_codeword_serializer.sv
//==============================================================================
// Module      : rs_codeword_serializer
// Description : Forwards K message bytes to a registered output stream with a
//               one-cycle latency. After the K-th byte, it snapshots the NPAR
//               encoder parity bytes and shifts them out highest first
//               (q[NPAR-1] .. q0). This forms one contiguous codeword with SOP
//               and EOP markers. In the same cycle it issues a one-cycle clear
//               to the encoder, so the next block starts with zero parity.
//               cnt is 8 bits wide, so K must be no larger than 256.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module rs_codeword_serializer #(
    parameter int K    = 239,
    parameter int NPAR = 16,
    parameter int W    = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    rs_codeword_serializer_if.slave bus
);

    localparam int         PW        = (NPAR > 1) ? $clog2(NPAR) : 1;
    localparam logic [7:0] LAST_CNT  = 8'(K - 1);
    localparam logic [PW-1:0] LAST_PIDX = PW'(NPAR - 1);

    typedef enum logic [0:0] {
        S_MSG = 1'b0,
        S_PAR = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [PW-1:0]   pidx_q, pidx_d;
    logic [W-1:0]    shadow_q [NPAR];
    logic [W-1:0]    shadow_d [NPAR];
    logic [W-1:0]    out_data_q, out_data_d;
    logic            out_valid_q, out_valid_d;
    logic            sop_q, sop_d;
    logic            eop_q, eop_d;
    logic            ovf_q, ovf_d;

    logic [W-1:0]    w_par_byte [NPAR];
    logic [PW-1:0]   w_rev_idx;
    logic [W-1:0]    w_emit_byte;
    logic            w_enc_clr;

    // Split the flat parity bus into per-register bytes; byte i is encoder q_i.
    for (genvar gi = 0; gi < NPAR; gi++) begin : g_par_unpack
        assign w_par_byte[gi] = bus.par_in[gi*W +: W];
    end

    // Emission runs from q[NPAR-1] down to q0.
    assign w_rev_idx = LAST_PIDX - pidx_q;

    // The first parity beat comes straight from the encoder, because the
    // shadow copy is only written at the end of that cycle. Later beats come
    // from the shadow, since the encoder has already been cleared by then.
    assign w_emit_byte = (pidx_q == '0) ? w_par_byte[NPAR-1] : shadow_q[w_rev_idx];

    // State, counters, shadow parity and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_MSG;
            cnt_q       <= '0;
            pidx_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            sop_q       <= 1'b0;
            eop_q       <= 1'b0;
            ovf_q       <= 1'b0;
            for (int i = 0; i < NPAR; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pidx_q      <= pidx_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            sop_q       <= sop_d;
            eop_q       <= eop_d;
            ovf_q       <= ovf_d;
            for (int i = 0; i < NPAR; i++) begin
                shadow_q[i] <= shadow_d[i];
            end
        end
    end

    // Next-state and output decode for message pass-through and parity shift-out.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pidx_d      = pidx_q;
        shadow_d    = shadow_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        sop_d       = 1'b0;
        eop_d       = 1'b0;
        ovf_d       = ovf_q;
        w_enc_clr   = 1'b0;

        case (state_q)
            S_MSG: begin
                if (bus.in_valid) begin
                    out_data_d  = bus.in_data;
                    out_valid_d = 1'b1;
                    sop_d       = (cnt_q == 8'd0);
                    if (cnt_q == LAST_CNT) begin
                        cnt_d   = '0;
                        state_d = S_PAR;
                    end else begin
                        cnt_d   = cnt_q + 8'd1;
                    end
                end
            end

            S_PAR: begin
                out_data_d  = w_emit_byte;
                out_valid_d = 1'b1;
                if (pidx_q == '0) begin
                    // The parity is final now; snapshot it and clear the encoder.
                    w_enc_clr = 1'b1;
                    shadow_d  = w_par_byte;
                end
                if (pidx_q == LAST_PIDX) begin
                    eop_d   = 1'b1;
                    pidx_d  = '0;
                    state_d = S_MSG;
                end else begin
                    pidx_d  = pidx_q + 1'b1;
                end
                // Bytes offered while busy are dropped and flagged.
                if (bus.in_valid) begin
                    ovf_d = 1'b1;
                end
            end

            default: begin
                state_d = S_MSG;
            end
        endcase
    end

    assign bus.in_busy   = (state_q == S_PAR);
    assign bus.enc_clr   = w_enc_clr;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sop   = sop_q;
    assign bus.out_eop   = eop_q;
    assign bus.cnt       = cnt_q;
    assign bus.ovf_err   = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_rs_codeword_serializer.sv
//==============================================================================
// Module      : tb_rs_codeword_serializer
// Description : Bench for rs_codeword_serializer. It contains an LFSR RS
//               encoder that supplies par_in, and a frame-level reference
//               model. The model computes parity by polynomial long division.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_rs_codeword_serializer;

    localparam int K    = 239;
    localparam int NPAR = 16;
    localparam int W    = 8;
    localparam int N    = K + NPAR;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    rs_codeword_serializer_if #(.NPAR(NPAR), .W(W)) bus ();

    rs_codeword_serializer #(.K(K), .NPAR(NPAR), .W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // GF(2^8) multiply with primitive polynomial 0x11D.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] x;
        r = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1D) : (x << 1);
        end
        return r;
    endfunction

    // Generator g(x) = prod (x + a^i) for i = 0..15; gp[k] is the coefficient of x^k.
    logic [7:0] gp [NPAR+1];

    // Encoder environment: LFSR division fed by the same strobe as the DUT.
    logic [7:0] enc_q [NPAR];
    logic [7:0] enc_n [NPAR];
    logic [7:0] enc_fb;

    always_comb begin
        enc_fb   = bus.in_data ^ enc_q[NPAR-1];
        enc_n[0] = gmul(gp[0], enc_fb);
        for (int i = 1; i < NPAR; i++) enc_n[i] = enc_q[i-1] ^ gmul(gp[i], enc_fb);
    end

    always @(posedge clk) begin
        if (rst || bus.enc_clr) begin
            for (int i = 0; i < NPAR; i++) enc_q[i] <= 8'h00;
        end else if (bus.in_valid) begin
            for (int i = 0; i < NPAR; i++) enc_q[i] <= enc_n[i];
        end
    end

    always_comb begin
        bus.par_in = '0;
        for (int i = 0; i < NPAR; i++) bus.par_in[i*8 +: 8] = enc_q[i];
    end

    // Reference model state
    logic [7:0] msg_m [K];
    logic [7:0] cw [N];
    logic [7:0] parq [$];
    int         acc;
    logic [7:0] exp_data;
    logic       exp_valid, exp_sop, exp_eop, exp_ovf;
    bit         have_exp;

    // Measured stream statistics
    int         run_len, max_run, clr_cnt, eop_cnt;
    logic [7:0] sop_data;

    // Codeword = message followed by remainder of m(x)*x^NPAR mod g(x).
    task automatic calc_codeword();
        logic [7:0] rem [N];
        for (int i = 0; i < N; i++) rem[i] = (i < K) ? msg_m[i] : 8'h00;
        for (int i = 0; i < K; i++) begin
            logic [7:0] c;
            c = rem[i];
            for (int j = 0; j <= NPAR; j++) rem[i+j] = rem[i+j] ^ gmul(c, gp[NPAR-j]);
        end
        for (int i = 0; i < N; i++) cw[i] = (i < K) ? msg_m[i] : rem[i];
    endtask

    function automatic logic [7:0] eval_cw(input logic [7:0] a);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < N; i++) r = gmul(r, a) ^ cw[i];
        return r;
    endfunction

    function automatic logic [7:0] eval_gen(input logic [7:0] a);
        logic [7:0] r;
        r = 8'h00;
        for (int k = NPAR; k >= 0; k--) r = gmul(r, a) ^ gp[k];
        return r;
    endfunction

    // Compare process: check the outputs against the model, then advance the model.
    initial begin
        have_exp = 0;
        acc      = 0;
        run_len  = 0;
        max_run  = 0;
        clr_cnt  = 0;
        eop_cnt  = 0;
        sop_data = 8'h00;
        exp_ovf  = 1'b0;
        forever begin
            @(negedge clk);
            if (have_exp) begin
                chk("out_valid", bus.out_valid, exp_valid);
                chk("out_data",  bus.out_data,  exp_data);
                chk("out_sop",   bus.out_sop,   exp_sop);
                chk("out_eop",   bus.out_eop,   exp_eop);
                chk("ovf_err",   bus.ovf_err,   exp_ovf);
                chk("cnt",       bus.cnt,       acc);
                chk("in_busy",   bus.in_busy,   parq.size() != 0);
                chk("enc_clr",   bus.enc_clr,   parq.size() == NPAR);
            end
            run_len = bus.out_valid ? run_len + 1 : 0;
            if (run_len > max_run) max_run = run_len;
            if (bus.enc_clr === 1'b1) clr_cnt++;
            if (bus.out_eop === 1'b1) eop_cnt++;
            if (bus.out_sop === 1'b1) sop_data = bus.out_data;

            if (rst) begin
                exp_data = 8'h00; exp_valid = 0; exp_sop = 0; exp_eop = 0; exp_ovf = 0;
                acc = 0;
                parq.delete();
            end else if (parq.size() != 0) begin
                if (bus.in_valid) exp_ovf = 1'b1;
                exp_data  = parq.pop_front();
                exp_valid = 1'b1;
                exp_sop   = 1'b0;
                exp_eop   = (parq.size() == 0);
            end else if (bus.in_valid) begin
                msg_m[acc] = bus.in_data;
                exp_data   = bus.in_data;
                exp_valid  = 1'b1;
                exp_sop    = (acc == 0);
                exp_eop    = 1'b0;
                acc++;
                if (acc == K) begin
                    calc_codeword();
                    for (int i = 0; i < NPAR; i++) parq.push_back(cw[K+i]);
                    acc = 0;
                end
            end else begin
                exp_valid = 1'b0;
                exp_sop   = 1'b0;
                exp_eop   = 1'b0;
            end
            have_exp = 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] d);
        bus.in_valid = v;
        bus.in_data  = d;
        tick();
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 8'($urandom));
    endtask

    // gap_mode: 0 contiguous, 1 every other cycle, 2 random gaps.
    // data_mode: 0 = 01,02,..; 1 = zeros; 2 = random.
    task automatic send_msg(input int gap_mode, input int data_mode, input int nbytes);
        for (int i = 0; i < nbytes; i++) begin
            logic [7:0] d;
            case (data_mode)
                0:       d = 8'(i + 1);
                1:       d = 8'h00;
                default: d = 8'($urandom);
            endcase
            if (gap_mode == 1 && i != 0) drive(1'b0, 8'h55);
            if (gap_mode == 2) begin
                while ($urandom_range(0, 3) == 0) drive(1'b0, 8'($urandom));
            end
            if (gap_mode == 1 && i == K - 1) chk("cnt_before_last", bus.cnt, 238);
            drive(1'b1, d);
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_out_data"},  bus.out_data,  0);
        chk({tag, "_out_valid"}, bus.out_valid, 0);
        chk({tag, "_out_sop"},   bus.out_sop,   0);
        chk({tag, "_out_eop"},   bus.out_eop,   0);
        chk({tag, "_in_busy"},   bus.in_busy,   0);
        chk({tag, "_enc_clr"},   bus.enc_clr,   0);
        chk({tag, "_cnt"},       bus.cnt,       0);
        chk({tag, "_ovf_err"},   bus.ovf_err,   0);
    endtask

    task automatic clear_stats();
        max_run = 0;
        clr_cnt = 0;
        eop_cnt = 0;
    endtask

    // Watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, tests=%0d", tests);
        $fatal(1);
    end

    // Main stimulus
    initial begin
        logic [7:0] a;
        logic [7:0] zacc;

        // Build the generator polynomial.
        for (int k = 0; k <= NPAR; k++) gp[k] = 8'h00;
        gp[0] = 8'h01;
        a = 8'h01;
        for (int r = 0; r < NPAR; r++) begin
            for (int k = NPAR; k >= 1; k--) gp[k] = gp[k-1] ^ gmul(a, gp[k]);
            gp[0] = gmul(a, gp[0]);
            a = gmul(a, 8'h02);
        end

        // Pin the model: field arithmetic, generator roots, codeword roots.
        chk("pin_gmul_80x02", gmul(8'h80, 8'h02), 8'h1D);
        chk("pin_gmul_1",     gmul(8'h01, 8'hC3), 8'hC3);
        a = 8'h01;
        for (int i = 0; i < 255; i++) a = gmul(a, 8'h02);
        chk("pin_alpha255", a, 8'h01);
        chk("pin_gen_monic", gp[NPAR], 8'h01);
        a = 8'h01;
        for (int j = 0; j < NPAR; j++) begin
            chk("pin_gen_root", eval_gen(a), 8'h00);
            a = gmul(a, 8'h02);
        end
        for (int i = 0; i < K; i++) msg_m[i] = 8'(i + 1);
        calc_codeword();
        a = 8'h01;
        for (int j = 0; j < NPAR; j++) begin
            chk("pin_cw_root", eval_cw(a), 8'h00);
            a = gmul(a, 8'h02);
        end
        for (int i = 0; i < K; i++) msg_m[i] = 8'h00;
        calc_codeword();
        zacc = 8'h00;
        for (int i = K; i < N; i++) zacc = zacc | cw[i];
        chk("pin_zero_parity", zacc, 8'h00);

        // Reset
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        tick();
        tick();
        check_reset_state("reset");
        rst = 1'b0;

        // 1: contiguous 01..EF
        clear_stats();
        send_msg(0, 0, K);
        idle(NPAR + 2);
        chk("s1_run_255", max_run, 255);
        chk("s1_clr_once", clr_cnt, 1);
        chk("s1_eop_once", eop_cnt, 1);
        chk("s1_sop_data", sop_data, 8'h01);

        // 2: every-other-cycle gaps, parity follows EF directly
        clear_stats();
        send_msg(1, 0, K);
        idle(NPAR + 2);
        chk("s2_tail_run", max_run, NPAR + 1);
        chk("s2_clr_once", clr_cnt, 1);

        // 3: back-to-back codewords, second is all zeros
        clear_stats();
        send_msg(0, 0, K);
        idle(NPAR);
        send_msg(0, 1, K);
        idle(NPAR + 2);
        chk("s3_run_510", max_run, 2 * N);
        chk("s3_eops", eop_cnt, 2);
        chk("s3_clrs", clr_cnt, 2);

        // 4: overflow byte on the fifth parity cycle
        send_msg(2, 2, K);
        idle(4);
        drive(1'b1, 8'hAA);
        idle(NPAR);
        chk("s4_ovf_set", bus.ovf_err, 1);
        idle(5);
        chk("s4_ovf_sticky", bus.ovf_err, 1);
        rst = 1'b1;
        drive(1'b0, 8'h00);
        rst = 1'b0;
        check_reset_state("s4_rst");

        // 5: reset after 100 message bytes, then a full frame
        send_msg(0, 0, 100);
        rst = 1'b1;
        drive(1'b0, 8'h00);
        rst = 1'b0;
        check_reset_state("s5_rst");
        clear_stats();
        send_msg(0, 0, K);
        idle(NPAR + 2);
        chk("s5_sop_data", sop_data, 8'h01);
        chk("s5_eop_once", eop_cnt, 1);

        // 6: reset during the third parity cycle
        send_msg(2, 2, K);
        idle(2);
        clear_stats();
        rst = 1'b1;
        drive(1'b0, 8'h00);
        rst = 1'b0;
        chk("s6_busy", bus.in_busy, 0);
        chk("s6_cnt", bus.cnt, 0);
        idle(NPAR);
        chk("s6_no_eop", eop_cnt, 0);
        send_msg(0, 2, K);
        idle(NPAR + 2);

        // Randomized frames
        for (int f = 0; f < 3; f++) begin
            send_msg(2, 2, K);
            idle(NPAR + $urandom_range(0, 3));
        end

        idle(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
